pwm_meas: RTL

Two-channel PWM capture block, the receive-side counterpart of `pwm_gen`. It measures period and high time of the drive/steer PWM signals arriving from the RF receiver pads (`pwm0_pad_i`, `pwm1_pad_i`) in `axi_clk` cycles. It publishes period/high-time pairs and status flags for `sys_ctrl_axi` to read back. It sits inside `sys_ctrl_top` alongside `pwm_gen` and `video_meas`.

---
 rtl/pwm_meas_pkg.sv | 11 +
 rtl/pwm_meas_ch.sv | 124 ++++++++++++
 rtl/pwm_meas.sv | 56 +++++
 3 files changed

// File: rtl/pwm_meas_pkg.sv
// Shared types for the two-channel PWM capture block.
// Holds the per-channel FSM state encoding used by pwm_meas_ch.
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_meas_state_t;

endpackage

// File: rtl/pwm_meas_ch.sv
// One PWM capture channel: sync + edge detect, rise-to-rise period and high time.
// Outputs change 1 cycle after edge detection (3 flops of input delay); no backpressure.
module pwm_meas_ch
  import pwm_meas_pkg::*;
#(
  parameter int CNT_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic                 axi_clk,
  input  logic                 axi_rstn,
  input  logic                 meas_enable_i,
  input  logic                 pwm_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] active_o,
  output logic                 valid_o,
  output logic                 lost_o,
  output logic                 upd_o
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic [1:0]           sync_q;
  logic                 dly;
  logic                 rise;
  logic                 fall;
  logic                 timeout;
  pwm_meas_state_t      state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] shadow;

  // Synchronizer is not gated by enable, so re-enabling never sees a stale edge.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      sync_q <= 2'b00;
      dly    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_i};
      dly    <= sync_q[1];
    end
  end

  assign rise    = sync_q[1] & ~dly;
  assign fall    = ~sync_q[1] & dly;
  assign timeout = (cnt == TIMEOUT_VAL) & ~rise;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      period_o <= '0;
      active_o <= '0;
      valid_o  <= 1'b0;
      lost_o   <= 1'b0;
      upd_o    <= 1'b0;
    end else begin
      upd_o <= 1'b0;
      if (!meas_enable_i) begin
        state    <= IDLE;
        cnt      <= '0;
        shadow   <= '0;
        period_o <= '0;
        active_o <= '0;
        valid_o  <= 1'b0;
        lost_o   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state  <= HIGH;
              cnt    <= CNT_ONE;
              lost_o <= 1'b0;
            end else begin
              cnt <= '0;
            end
          end
          HIGH: begin
            if (timeout) begin
              state    <= IDLE;
              cnt      <= '0;
              period_o <= '0;
              active_o <= '0;
              valid_o  <= 1'b0;
              lost_o   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall) begin
                state  <= LOW;
                shadow <= cnt;
              end
            end
          end
          LOW: begin
            // A rise landing on the timeout cycle still captures a period.
            if (rise) begin
              state    <= HIGH;
              cnt      <= CNT_ONE;
              period_o <= cnt;
              active_o <= shadow;
              valid_o  <= 1'b1;
              upd_o    <= 1'b1;
              lost_o   <= 1'b0;
            end else if (timeout) begin
              state    <= IDLE;
              cnt      <= '0;
              period_o <= '0;
              active_o <= '0;
              valid_o  <= 1'b0;
              lost_o   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_meas.sv
// Two independent PWM capture channels sharing one clock, reset and enable.
// Latency as pwm_meas_ch (outputs 1 cycle after edge detection); no backpressure.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int CNT_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic                 axi_clk,
  input  logic                 axi_rstn,
  input  logic                 meas_enable_i,
  input  logic                 pwm_0_i,
  input  logic                 pwm_1_i,
  output logic [CNT_WIDTH-1:0] period_0_o,
  output logic [CNT_WIDTH-1:0] active_0_o,
  output logic                 valid_0_o,
  output logic                 lost_0_o,
  output logic                 upd_0_o,
  output logic [CNT_WIDTH-1:0] period_1_o,
  output logic [CNT_WIDTH-1:0] active_1_o,
  output logic                 valid_1_o,
  output logic                 lost_1_o,
  output logic                 upd_1_o
);

  pwm_meas_ch #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ch0 (
    .axi_clk       (axi_clk),
    .axi_rstn      (axi_rstn),
    .meas_enable_i (meas_enable_i),
    .pwm_i         (pwm_0_i),
    .period_o      (period_0_o),
    .active_o      (active_0_o),
    .valid_o       (valid_0_o),
    .lost_o        (lost_0_o),
    .upd_o         (upd_0_o)
  );

  pwm_meas_ch #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ch1 (
    .axi_clk       (axi_clk),
    .axi_rstn      (axi_rstn),
    .meas_enable_i (meas_enable_i),
    .pwm_i         (pwm_1_i),
    .period_o      (period_1_o),
    .active_o      (active_1_o),
    .valid_o       (valid_1_o),
    .lost_o        (lost_1_o),
    .upd_o         (upd_1_o)
  );

endmodule
